// File: rtl/mem_arbiter.sv
// Round-robin arbiter that lets NUM_CH cache channels share one line-wide physical memory port.
// Define MEM_ARBITER_FIXED_PRIO_EN to make the lowest-index requester always win instead.
module mem_arbiter #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_CH-1:0]          req_read,
   input  logic [NUM_CH-1:0]          req_write,
   input  logic [NUM_CH*ADDR_W-1:0]   req_address,
   input  logic [NUM_CH*LINE_W-1:0]   req_wdata,
   output logic [NUM_CH-1:0]          req_resp,
   output logic [LINE_W-1:0]          req_rdata,
   output logic                       pmem_read,
   output logic                       pmem_write,
   output logic [ADDR_W-1:0]          pmem_address,
   output logic [LINE_W-1:0]          pmem_wdata,
   input  logic [LINE_W-1:0]          pmem_rdata,
   input  logic                       pmem_resp
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    winner_q, winner_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic                op_write_q, op_write_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LINE_W-1:0]   wdata_q, wdata_d;
   logic [LINE_W-1:0]   rdata_q, rdata_d;

   logic [NUM_CH-1:0]   any_req;
   logic [IDX_W-1:0]    search_base;
   logic [IDX_W-1:0]    grant_idx;
   logic                grant_found;
   int unsigned         cand;

   // Search upward from the base with wrap-around; first requester found wins.
   always_comb begin
      any_req     = req_read | req_write;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
      search_base = '0;
`else
      search_base = rr_ptr_q;
`endif
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         cand = (int'(search_base) + k) % NUM_CH;
         if (!grant_found && any_req[cand]) begin
            grant_found = 1'b1;
            grant_idx   = IDX_W'(cand);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      winner_d   = winner_q;
      rr_ptr_d   = rr_ptr_q;
      op_write_d = op_write_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      case (state_q)
         IDLE: begin
            if (grant_found) begin
               winner_d   = grant_idx;
               op_write_d = req_write[grant_idx];
               addr_d     = req_address[grant_idx*ADDR_W +: ADDR_W];
               wdata_d    = req_wdata[grant_idx*LINE_W +: LINE_W];
               state_d    = BUSY;
            end
         end
         BUSY: begin
            if (pmem_resp) begin
               if (!op_write_q) rdata_d = pmem_rdata;
               state_d = RESP;
            end
         end
         RESP: begin
`ifndef MEM_ARBITER_FIXED_PRIO_EN
            rr_ptr_d = (winner_q == IDX_W'(NUM_CH-1)) ? '0 : winner_q + 1'b1;
`endif
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         winner_q   <= '0;
         rr_ptr_q   <= '0;
         op_write_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         winner_q   <= winner_d;
         rr_ptr_q   <= rr_ptr_d;
         op_write_q <= op_write_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
      end
   end

   assign pmem_read    = (state_q == BUSY) && !op_write_q;
   assign pmem_write   = (state_q == BUSY) &&  op_write_q;
   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;
   assign req_rdata    = rdata_q;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_resp
         assign req_resp[gi] = (state_q == RESP) && (winner_q == IDX_W'(gi));
      end
   endgenerate

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table on a 2-channel instance, randomized
// traffic against a transaction-level reference model on a 4-channel instance.
module tb_mem_arbiter;

   localparam int AW = 16;
   localparam int LW = 128;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 2-channel instance
   logic            a_rst_n;
   logic [1:0]      a_rd, a_wr, a_resp;
   logic [2*AW-1:0] a_addr;
   logic [2*LW-1:0] a_wdata;
   logic [LW-1:0]   a_rdata, a_pwdata, a_prdata;
   logic            a_pread, a_pwrite, a_presp;
   logic [AW-1:0]   a_paddr;

   // 4-channel instance
   logic            b_rst_n;
   logic [3:0]      b_rd, b_wr, b_resp;
   logic [4*AW-1:0] b_addr;
   logic [4*LW-1:0] b_wdata;
   logic [LW-1:0]   b_rdata, b_pwdata, b_prdata;
   logic            b_pread, b_pwrite, b_presp;
   logic [AW-1:0]   b_paddr;

   mem_arbiter #(.NUM_CH(2), .ADDR_W(AW), .LINE_W(LW)) dut_a (
      .clk(clk), .rst_n(a_rst_n),
      .req_read(a_rd), .req_write(a_wr), .req_address(a_addr), .req_wdata(a_wdata),
      .req_resp(a_resp), .req_rdata(a_rdata),
      .pmem_read(a_pread), .pmem_write(a_pwrite), .pmem_address(a_paddr),
      .pmem_wdata(a_pwdata), .pmem_rdata(a_prdata), .pmem_resp(a_presp)
   );

   mem_arbiter #(.NUM_CH(4), .ADDR_W(AW), .LINE_W(LW)) dut_b (
      .clk(clk), .rst_n(b_rst_n),
      .req_read(b_rd), .req_write(b_wr), .req_address(b_addr), .req_wdata(b_wdata),
      .req_resp(b_resp), .req_rdata(b_rdata),
      .pmem_read(b_pread), .pmem_write(b_pwrite), .pmem_address(b_paddr),
      .pmem_wdata(b_pwdata), .pmem_rdata(b_prdata), .pmem_resp(b_presp)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [LW-1:0] rnd_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   typedef struct {
      logic [1:0]    rd;
      logic [1:0]    wr;
      logic [AW-1:0] addr0;
      logic [AW-1:0] addr1;
      logic [LW-1:0] wd0;
      logic [LW-1:0] wd1;
      int            delay;
      logic [LW-1:0] prdata;
      int            exp_ch;
      logic          exp_we;
   } vec_t;

   logic [LW-1:0] last_rd_a = '0;

   // One full transaction on the 2-channel instance: request, busy, resp, idle.
   task automatic run_vec(input int id, input vec_t v);
      logic [AW-1:0] ea;
      logic [LW-1:0] ew;
      @(negedge clk);
      a_rd = v.rd; a_wr = v.wr;
      a_addr = {v.addr1, v.addr0}; a_wdata = {v.wd1, v.wd0}; a_presp = 1'b0;
      ea = (v.exp_ch == 1) ? v.addr1 : v.addr0;
      ew = (v.exp_ch == 1) ? v.wd1 : v.wd0;
      @(negedge clk);
      a_addr = ~a_addr; a_wdata = ~a_wdata;
      for (int k = 1; k <= v.delay; k++) begin
         if (k > 1) @(negedge clk);
         chk($sformatf("v%0d busy%0d pmem_read", id, k), a_pread, !v.exp_we);
         chk($sformatf("v%0d busy%0d pmem_write", id, k), a_pwrite, v.exp_we);
         chk($sformatf("v%0d busy%0d pmem_address", id, k), a_paddr, ea);
         if (v.exp_we) chk($sformatf("v%0d busy%0d pmem_wdata", id, k), a_pwdata, ew);
         chk($sformatf("v%0d busy%0d req_resp", id, k), a_resp, 2'b00);
         a_presp  = (k == v.delay);
         a_prdata = (k == v.delay) ? v.prdata : rnd_line();
      end
      @(negedge clk);
      a_presp = 1'b0;
      if (!v.exp_we) last_rd_a = v.prdata;
      chk($sformatf("v%0d req_resp", id), a_resp, 2'b01 << v.exp_ch);
      chk($sformatf("v%0d req_rdata", id), a_rdata, last_rd_a);
      chk($sformatf("v%0d pmem idle in resp", id), {a_pread, a_pwrite}, 2'b00);
      a_rd = '0; a_wr = '0;
      @(negedge clk);
      chk($sformatf("v%0d req_resp after pulse", id), a_resp, 2'b00);
      chk($sformatf("v%0d req_rdata hold", id), a_rdata, last_rd_a);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[7];
      int   cyc, prev, ch, exp_ch;
      bit   found;
      int   order[3];

      // Directed table; round-robin pointer is 0 after reset.
      vecs[0] = '{2'b01, 2'b00, 16'h1230, 16'h0000, '0, '0, 3, {4{32'hDEADBEEF}}, 0, 1'b0};
      vecs[1] = '{2'b00, 2'b10, 16'h0000, 16'h0040, '0, {16{8'hA5}}, 2, {4{32'h11111111}}, 1, 1'b1};
      vecs[2] = '{2'b01, 2'b01, 16'h0300, 16'h0000, {8{16'h1234}}, '0, 1, {4{32'h22222222}}, 0, 1'b1};
`ifdef MEM_ARBITER_FIXED_PRIO_EN
      vecs[3] = '{2'b11, 2'b00, 16'h0010, 16'h0020, '0, '0, 2, {4{32'h0BADF00D}}, 0, 1'b0};
`else
      vecs[3] = '{2'b11, 2'b00, 16'h0010, 16'h0020, '0, '0, 2, {4{32'h0BADF00D}}, 1, 1'b0};
`endif
      vecs[4] = '{2'b11, 2'b00, 16'h0011, 16'h0021, '0, '0, 1, {4{32'hCAFEF00D}}, 0, 1'b0};
      vecs[5] = '{2'b10, 2'b00, 16'h0000, 16'h00FF, '0, '0, 4, {4{32'h76543210}}, 1, 1'b0};
      vecs[6] = '{2'b10, 2'b01, 16'h0A0A, 16'h0B0B, {8{16'h5A5A}}, '0, 2, {4{32'h33333333}}, 0, 1'b1};

      a_rst_n = 1'b0; a_rd = '0; a_wr = '0; a_addr = '0; a_wdata = '0;
      a_presp = 1'b1; a_prdata = rnd_line();
      b_rst_n = 1'b0; b_rd = '0; b_wr = '0; b_addr = '0; b_wdata = '0;
      b_presp = 1'b0; b_prdata = '0;
      repeat (3) @(negedge clk);
      chk("reset req_resp", a_resp, 2'b00);
      chk("reset pmem cmd", {a_pread, a_pwrite}, 2'b00);
      chk("reset pmem_address", a_paddr, '0);
      chk("reset pmem_wdata", a_pwdata, '0);
      chk("reset req_rdata", a_rdata, '0);
      chk("reset b outputs", {b_resp, b_pread, b_pwrite, b_paddr}, '0);
      a_rst_n = 1'b1; a_presp = 1'b0;

      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

      // Contention from reset with both channels requesting continuously.
      @(negedge clk); a_rst_n = 1'b0;
      @(negedge clk); a_rst_n = 1'b1;
      a_rd = 2'b11; a_wr = 2'b00; a_addr = {16'h0200, 16'h0100};
`ifdef MEM_ARBITER_FIXED_PRIO_EN
      order = '{0, 0, 0};
`else
      order = '{0, 1, 0};
`endif
      cyc = 0; prev = 0;
      for (int g = 0; g < 3; g++) begin
         found = 1'b0;
         for (int w = 0; w < 10 && !found; w++) begin
            @(negedge clk); cyc++;
            if (a_pread) found = 1'b1;
         end
         chk($sformatf("contention grant%0d seen", g), found, 1'b1);
         if (!found) break;
         ch = (a_paddr == 16'h0200) ? 1 : 0;
         chk($sformatf("contention grant%0d channel", g), ch, order[g]);
         if (g > 0) chk($sformatf("contention grant%0d spacing", g), cyc - prev, 3);
         prev = cyc;
         a_presp = 1'b1; a_prdata = rnd_line();
         @(negedge clk); cyc++;
         a_presp = 1'b0;
         chk($sformatf("contention grant%0d req_resp", g), a_resp, 2'b01 << ch);
      end
      a_rd = '0;

      // Reset in BUSY, then a late pmem_resp; next grant must restart at ch0.
      @(negedge clk); a_rd = 2'b01; a_addr = {16'h0000, 16'h0500};
      @(negedge clk);
      chk("abort busy pmem_read", a_pread, 1'b1);
      a_rst_n = 1'b0; a_rd = '0;
      @(negedge clk);
      chk("abort pmem cmd dropped", {a_pread, a_pwrite}, 2'b00);
      chk("abort no req_resp", a_resp, 2'b00);
      a_rst_n = 1'b1; a_presp = 1'b1;
      @(negedge clk);
      a_presp = 1'b0;
      chk("late pmem_resp no req_resp", a_resp, 2'b00);
      chk("late pmem_resp pmem idle", {a_pread, a_pwrite}, 2'b00);
      a_rd = 2'b11; a_addr = {16'h0700, 16'h0600};
      @(negedge clk);
      chk("post-abort grant address", a_paddr, 16'h0600);
      chk("post-abort grant read", a_pread, 1'b1);
      a_presp = 1'b1;
      @(negedge clk);
      a_presp = 1'b0; a_rd = '0;
      chk("post-abort req_resp", a_resp, 2'b01);

      // Randomized traffic on the 4-channel instance against a transaction model.
      begin
         bit            pend[4];
         logic          we_p[4];
         logic [AW-1:0] addr_p[4];
         logic [LW-1:0] wd_p[4];
         int            ptr, w, delay, prob, start, op, last_end;
         bit            inflight, resp_due, idle_now, busy_now, prev_active, any;
         logic          m_we;
         logic [AW-1:0] m_addr;
         logic [LW-1:0] m_wd, last_rd;
         ptr = 0; w = 0; delay = 0; inflight = 0; resp_due = 0;
         m_we = 0; m_addr = '0; m_wd = '0; last_rd = '0;
         prev_active = 0; last_end = -100;
         for (int c = 0; c < 4; c++) begin
            pend[c] = 0; we_p[c] = 0; addr_p[c] = '0; wd_p[c] = '0;
         end
         @(negedge clk); b_rst_n = 1'b1;
         for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            // compare this cycle's outputs with the model
            chk($sformatf("R t%0d pmem_read", t), b_pread, inflight && !m_we);
            chk($sformatf("R t%0d pmem_write", t), b_pwrite, inflight && m_we);
            if (inflight) chk($sformatf("R t%0d pmem_address", t), b_paddr, m_addr);
            if (inflight && m_we) chk($sformatf("R t%0d pmem_wdata", t), b_pwdata, m_wd);
            chk($sformatf("R t%0d req_resp", t), b_resp, resp_due ? (4'b0001 << w) : 4'b0000);
            chk($sformatf("R t%0d req_rdata", t), b_rdata, last_rd);
            if ((b_pread || b_pwrite) && !prev_active)
               chk($sformatf("R t%0d pmem gap>=2", t), (t - last_end - 1) >= 2, 1'b1);
            if (!(b_pread || b_pwrite) && prev_active) last_end = t - 1;
            prev_active = b_pread || b_pwrite;

            // advance the model and drive this cycle's inputs
            idle_now = !inflight && !resp_due;
            busy_now = inflight;
            if (resp_due) begin
               pend[w] = 0;
               resp_due = 0;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
               ptr = (w + 1) % 4;
`endif
            end
            prob = (t < 200) ? 100 : 35;
            for (int c = 0; c < 4; c++) begin
               if (!pend[c] && $urandom_range(99) < prob) begin
                  pend[c] = 1;
                  op = $urandom_range(2);
                  we_p[c] = (op != 0);
                  addr_p[c] = AW'($urandom);
                  wd_p[c] = rnd_line();
                  b_rd[c] = (op != 1);
                  b_wr[c] = (op != 0);
               end else if (!pend[c]) begin
                  b_rd[c] = 1'b0;
                  b_wr[c] = 1'b0;
               end
               b_addr[c*AW +: AW]  = pend[c] && !busy_now ? addr_p[c] : AW'($urandom);
               b_wdata[c*LW +: LW] = pend[c] && !busy_now ? wd_p[c] : rnd_line();
            end
            b_prdata = rnd_line();
            if (busy_now) begin
               delay--;
               b_presp = (delay == 0);
               if (delay == 0) begin
                  inflight = 0;
                  resp_due = 1;
                  if (!m_we) last_rd = b_prdata;
               end
            end else begin
               b_presp = ($urandom_range(3) == 0);
            end
            if (idle_now) begin
               any = 0;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
               start = 0;
`else
               start = ptr;
`endif
               for (int k = 0; k < 4; k++) begin
                  if (!any && pend[(start + k) % 4]) begin
                     any = 1;
                     w = (start + k) % 4;
                  end
               end
               if (any) begin
                  inflight = 1;
                  m_we = we_p[w];
                  m_addr = addr_p[w];
                  m_wd = wd_p[w];
                  delay = $urandom_range(1, 4);
               end
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2, number of requesting cache channels (legal 2..8).
REQ-002 Parameter ADDR_W, default 16, word address width.
REQ-003 Parameter LINE_W, default 128, cache line width in bits.
REQ-004 The block SHALL use one clock, clk, and a synchronous active-low reset, rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 req_read  input  NUM_CH  per-channel line read request.
REQ-008 req_write  input  NUM_CH  per-channel line write request.
REQ-009 req_address  input  NUM_CH*ADDR_W  per-channel line address; channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 req_wdata  input  NUM_CH*LINE_W  per-channel write line; channel i occupies bits [i*LINE_W +: LINE_W].
REQ-011 req_resp  output  NUM_CH  one-hot completion pulse to the granted channel.
REQ-012 req_rdata  output  LINE_W  read line, shared by all channels, valid while req_resp is nonzero.
REQ-013 pmem_read, pmem_write  output  1 each  physical memory command.
REQ-014 pmem_address  output  ADDR_W; pmem_wdata  output  LINE_W.
REQ-015 pmem_rdata  input  LINE_W; pmem_resp  input  1  physical memory completion.

Function
REQ-016 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-017 IDLE: if any channel has req_read or req_write high, select a winner, register the winner index, op, address and wdata, then go to BUSY; otherwise stay in IDLE.
REQ-018 Winner selection: round-robin. Search starts at the rr_ptr index and proceeds upward, with wrap-around modulo NUM_CH.
REQ-019 A channel with both req_read and req_write high SHALL be serviced as a write.
REQ-020 BUSY: drive pmem_read or pmem_write, pmem_address and pmem_wdata from the registered values, held stable until pmem_resp; requester input changes are ignored.
REQ-021 BUSY with pmem_resp=1: on a read, capture pmem_rdata into req_rdata; go to RESP.
REQ-022 RESP: assert req_resp[winner]=1 for exactly one cycle; set rr_ptr=(winner+1) mod NUM_CH; go to IDLE.
REQ-023 Latency: a request first seen in IDLE at cycle N asserts pmem_* at N+1; pmem_resp at cycle M asserts req_resp at M+1; the next grant is at the earliest M+2.
REQ-024 A requester SHALL drop its request at the edge where it samples req_resp; a request still high in IDLE is treated as a new request.
REQ-025 pmem_read and pmem_write SHALL never both be high, and SHALL be 0 outside BUSY.
REQ-026 pmem_resp in IDLE or RESP SHALL be ignored.
REQ-027 req_rdata SHALL hold its last captured value when not updated; on writes it is unchanged.

Reset
REQ-028 With rst_n=0 at a clk edge: state=IDLE, rr_ptr=0, req_resp=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, req_rdata=0.
REQ-029 Reset during BUSY or RESP SHALL abort the transaction: no req_resp pulse, and pmem commands drop on the next cycle.

Configuration
REQ-030 Macro MEM_ARBITER_FIXED_PRIO_EN.
REQ-031 When defined, the lowest-index requesting channel always wins and rr_ptr is neither used nor updated.
REQ-032 When undefined, round-robin per REQ-018/REQ-022 applies.

Verification
REQ-033 Single read: ch0 read, addr 0x1230, pmem_resp after 3 cycles with rdata 0xDEADBEEF_... -> pmem_read at 0x1230 for 3 cycles, req_resp=2'b01 one cycle later with matching req_rdata.
REQ-034 Contention: ch0 and ch1 both read from reset -> ch0 served first, then ch1; with ch0 re-requesting, the order continues ch0, ch1, ch0 (round-robin); with MEM_ARBITER_FIXED_PRIO_EN, ch0 always wins.
REQ-035 Write: ch1 write, addr 0x0040, wdata 0xA5...A5 -> pmem_write=1, pmem_wdata equals 0xA5...A5, req_resp=2'b10, req_rdata unchanged.
REQ-036 Read+write on ch0 simultaneously -> pmem_write only, never pmem_read.
REQ-037 rst_n=0 during BUSY, then late pmem_resp -> pmem_read=0 next cycle, no req_resp, state IDLE, next grant goes to ch0.
REQ-038 NUM_CH=4 with all channels requesting continuously -> grants 0,1,2,3,0 with wrap-around, and no pmem gap shorter than 2 cycles between transactions.
